// File: rtl/svm_pkg.sv
// ---------------------------------------------------------------------------
// svm_pkg : shared widths, phase-state enum and index-width helper
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package svm_pkg;

  localparam int XLEN_PIXEL_DEF          = 8;
  localparam int KW_DEF                  = 5 * XLEN_PIXEL_DEF;
  localparam int CW_DEF                  = 2 * XLEN_PIXEL_DEF;
  localparam int DECISION_FUNCT_SIZE_DEF = 56;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    KERNEL = 2'd1,
    ACCUM  = 2'd2,
    FINISH = 2'd3
  } svm_state_t;

  // Width of an index/counter covering 0..n-1, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/svm_decision_unit_if.sv
// ---------------------------------------------------------------------------
// svm_decision_unit_if : kernel/coefficient inputs and decision outputs
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface svm_decision_unit_if #(
  parameter int XLEN_PIXEL          = 8,
  parameter int NUM_OF_SV           = 87,
  parameter int DECISION_FUNCT_SIZE = 56
);

  localparam int KW = 5 * XLEN_PIXEL;
  localparam int CW = 2 * XLEN_PIXEL;
  localparam int IW = svm_pkg::idx_w(NUM_OF_SV);

  logic                           en;
  logic [NUM_OF_SV*KW-1:0]        kernel_out;
  logic [IW-1:0]                  coef_addr;
  logic [CW-1:0]                  coef_data;
  logic [CW-1:0]                  b;
  logic                           kernel_busy;
  logic                           decision_funct_en;
  logic [DECISION_FUNCT_SIZE-1:0] decision_funct_out;
  logic                           y_class;
  logic                           done;

  modport master (
    output en, kernel_out, coef_data, b,
    input  coef_addr, kernel_busy, decision_funct_en,
           decision_funct_out, y_class, done
  );

  modport slave (
    input  en, kernel_out, coef_data, b,
    output coef_addr, kernel_busy, decision_funct_en,
           decision_funct_out, y_class, done
  );

endinterface

`default_nettype wire

// File: rtl/svm_phase_ctrl.sv
// ---------------------------------------------------------------------------
// svm_phase_ctrl : IDLE->KERNEL->ACCUM->FINISH sequencer with registered strobes
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module svm_phase_ctrl
  import svm_pkg::*;
#(
  parameter int NUM_OF_SV      = 87,
  parameter int KERNEL_LATENCY = 784
) (
  input  wire logic                       clk,
  input  wire logic                       rst,
  input  wire logic                       en,
  output logic                            kernel_busy,
  output logic                            accum_en,
  output logic [idx_w(NUM_OF_SV)-1:0]     coef_addr,
  output logic                            acc_clr,
  output logic                            finish,
  output logic                            done
);

  localparam int IW = idx_w(NUM_OF_SV);
  localparam int CNT_W = idx_w(KERNEL_LATENCY);
  localparam logic [IW-1:0]    c_sv_last  = IW'(NUM_OF_SV - 1);
  localparam logic [CNT_W-1:0] c_lat_last = CNT_W'(KERNEL_LATENCY - 1);

  svm_state_t       state;
  logic [CNT_W-1:0] cnt;

  assign acc_clr = (state == IDLE) && en;

  // Strobes are loaded with the value matching the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      coef_addr   <= '0;
      kernel_busy <= 1'b0;
      accum_en    <= 1'b0;
      finish      <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (en) begin
            state       <= KERNEL;
            cnt         <= '0;
            coef_addr   <= '0;
            kernel_busy <= 1'b1;
          end
        end
        KERNEL: begin
          if (cnt == c_lat_last) begin
            state       <= ACCUM;
            kernel_busy <= 1'b0;
            accum_en    <= 1'b1;
            coef_addr   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ACCUM: begin
          if (coef_addr == c_sv_last) begin
            state    <= FINISH;
            accum_en <= 1'b0;
            finish   <= 1'b1;
          end else begin
            coef_addr <= coef_addr + 1'b1;
          end
        end
        FINISH: begin
          state     <= IDLE;
          finish    <= 1'b0;
          coef_addr <= '0;
          done      <= 1'b1;
        end
        default: begin
          state       <= IDLE;
          kernel_busy <= 1'b0;
          accum_en    <= 1'b0;
          finish      <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/svm_decision_unit.sv
// ---------------------------------------------------------------------------
// svm_decision_unit : serial sum(kernel*coef) + bias decision datapath
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module svm_decision_unit
  import svm_pkg::*;
#(
  parameter int XLEN_PIXEL          = XLEN_PIXEL_DEF,
  parameter int NUM_OF_SV           = 87,
  parameter int DECISION_FUNCT_SIZE = DECISION_FUNCT_SIZE_DEF,
  parameter int KERNEL_LATENCY      = 784
) (
  input  wire logic           clk,
  input  wire logic           rst,
  svm_decision_unit_if.slave  bus
);

  localparam int KW  = 5 * XLEN_PIXEL;
  localparam int CW  = 2 * XLEN_PIXEL;
  localparam int IW  = idx_w(NUM_OF_SV);
  localparam int DFS = DECISION_FUNCT_SIZE;

  logic [KW-1:0] kern_arr [NUM_OF_SV];

  for (genvar g = 0; g < NUM_OF_SV; g++) begin : g_kern_unpack
    assign kern_arr[g] = bus.kernel_out[g*KW +: KW];
  end

  logic          acc_clr;
  logic          accum_en;
  logic          finish;
  logic [IW-1:0] idx;

  svm_phase_ctrl #(
    .NUM_OF_SV      (NUM_OF_SV),
    .KERNEL_LATENCY (KERNEL_LATENCY)
  ) u_phase_ctrl (
    .clk         (clk),
    .rst         (rst),
    .en          (bus.en),
    .kernel_busy (bus.kernel_busy),
    .accum_en    (accum_en),
    .coef_addr   (idx),
    .acc_clr     (acc_clr),
    .finish      (finish),
    .done        (bus.done)
  );

  assign bus.decision_funct_en = accum_en;
  assign bus.coef_addr         = idx;

  logic signed [DFS-1:0] kern_ext;
  logic signed [DFS-1:0] coef_ext;
  logic signed [DFS-1:0] bias_ext;
  logic signed [DFS-1:0] prod;
  logic signed [DFS-1:0] sum;
  logic signed [DFS-1:0] acc;
  logic        [DFS-1:0] dfo_r;
  logic                  y_r;

  // Operands are extended to the full accumulator width so the truncated
  // product is already the correct result modulo 2^DFS.
  assign kern_ext = signed'({{(DFS-KW){1'b0}}, kern_arr[idx]});
  assign coef_ext = signed'({{(DFS-CW){bus.coef_data[CW-1]}}, bus.coef_data});
  assign bias_ext = signed'({{(DFS-CW){bus.b[CW-1]}}, bus.b});
  assign prod     = kern_ext * coef_ext;
  assign sum      = acc + bias_ext;

  always_ff @(posedge clk) begin
    if (rst) begin
      acc   <= '0;
      dfo_r <= '0;
      y_r   <= 1'b0;
    end else begin
      if (acc_clr) begin
        acc <= '0;
      end else if (accum_en) begin
        acc <= acc + prod;
      end
      if (finish) begin
        dfo_r <= sum;
        y_r   <= ~sum[DFS-1];
      end
    end
  end

  assign bus.decision_funct_out = dfo_r;
  assign bus.y_class            = y_r;

endmodule

`default_nettype wire

// File: tb/tb_svm_decision_unit.sv
// ---------------------------------------------------------------------------
// tb_svm_decision_unit : directed checks on a 4-SV instance and a default one
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_svm_decision_unit;

  logic clk;
  logic rst;

  int n_checks;
  int n_fail;

  svm_decision_unit_if #(.XLEN_PIXEL(8), .NUM_OF_SV(4), .DECISION_FUNCT_SIZE(56)) sbus ();
  svm_decision_unit_if #(.XLEN_PIXEL(8), .NUM_OF_SV(87), .DECISION_FUNCT_SIZE(56)) dbus ();

  svm_decision_unit #(
    .XLEN_PIXEL(8), .NUM_OF_SV(4), .DECISION_FUNCT_SIZE(56), .KERNEL_LATENCY(3)
  ) u_small (
    .clk (clk),
    .rst (rst),
    .bus (sbus.slave)
  );

  svm_decision_unit #(
    .XLEN_PIXEL(8), .NUM_OF_SV(87), .DECISION_FUNCT_SIZE(56), .KERNEL_LATENCY(784)
  ) u_default (
    .clk (clk),
    .rst (rst),
    .bus (dbus.slave)
  );

  logic signed [15:0] coef_arr [4];

  assign sbus.coef_data = coef_arr[sbus.coef_addr];
  assign dbus.coef_data = 16'h8000;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_coefs(input int c0, input int c1, input int c2, input int c3);
    coef_arr[0] = 16'(c0);
    coef_arr[1] = 16'(c1);
    coef_arr[2] = 16'(c2);
    coef_arr[3] = 16'(c3);
  endtask

  // Pulse en, wait for done (bounded), check latency and results.
  task automatic run_small(input string tag, input logic [55:0] exp_dfo, input logic exp_y);
    int n;
    sbus.en = 1'b1;
    tick();
    sbus.en = 1'b0;
    n = 0;
    while (!sbus.done && n < 50) begin
      tick();
      n++;
    end
    check({tag, "_latency"}, 64'(n), 64'd8);
    check({tag, "_dfo"}, 64'(sbus.decision_funct_out), 64'(exp_dfo));
    check({tag, "_y"}, 64'(sbus.y_class), 64'(exp_y));
  endtask

  initial begin
    int busy_cnt;
    int en_cnt;
    int done_cnt;
    int done_at;
    int exp_idx;
    int d_times [3];
    int n;

    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    sbus.en  = 1'b0;
    dbus.en  = 1'b0;
    sbus.b   = 16'd5;
    dbus.b   = 16'h8000;
    sbus.kernel_out = {40'd40, 40'd30, 40'd20, 40'd10};
    dbus.kernel_out = '1;
    set_coefs(1, -1, 2, 0);
    repeat (3) tick();
    rst = 1'b0;
    tick();

    check("rst_busy", 64'(sbus.kernel_busy), 64'd0);
    check("rst_dfen", 64'(sbus.decision_funct_en), 64'd0);
    check("rst_addr", 64'(sbus.coef_addr), 64'd0);
    check("rst_dfo", 64'(sbus.decision_funct_out), 64'd0);
    check("rst_y", 64'(sbus.y_class), 64'd0);
    check("rst_done", 64'(sbus.done), 64'd0);
    check("rst_dfo_def", 64'(dbus.decision_funct_out), 64'd0);

    // Nominal run, traced cycle by cycle: 10*1 - 20 + 30*2 + 0 + 5 = 55
    busy_cnt = 0; en_cnt = 0; done_cnt = 0; done_at = -1; exp_idx = 0;
    sbus.en = 1'b1;
    tick();
    sbus.en = 1'b0;
    for (int c = 0; c <= 10; c++) begin
      if (c > 0) tick();
      if (sbus.kernel_busy) busy_cnt++;
      if (sbus.decision_funct_en) begin
        check("nom_coef_addr", 64'(sbus.coef_addr), 64'(exp_idx));
        exp_idx++;
        en_cnt++;
      end
      if (sbus.done) begin
        done_cnt++;
        done_at = c;
      end
    end
    check("nom_busy_cycles", 64'(busy_cnt), 64'd3);
    check("nom_dfen_cycles", 64'(en_cnt), 64'd4);
    check("nom_done_count", 64'(done_cnt), 64'd1);
    check("nom_done_edge", 64'(done_at), 64'd8);
    check("nom_dfo", 64'(sbus.decision_funct_out), 64'd55);
    check("nom_y", 64'(sbus.y_class), 64'd1);
    repeat (3) tick();
    check("nom_hold_dfo", 64'(sbus.decision_funct_out), 64'd55);

    // Negative: -(10+20+30+40) = -100
    set_coefs(-1, -1, -1, -1);
    sbus.b = 16'd0;
    run_small("neg", 56'hFF_FFFF_FFFF_FF9C, 1'b0);

    set_coefs(0, 0, 0, 0);
    run_small("zero", 56'd0, 1'b1);

    // en pulses inside KERNEL and ACCUM must be ignored
    set_coefs(1, -1, 2, 0);
    sbus.b = 16'd5;
    sbus.en = 1'b1;
    tick();
    sbus.en = 1'b0;
    tick();
    sbus.en = 1'b1;
    tick();
    sbus.en = 1'b0;
    tick();
    tick();
    check("ign_in_accum", 64'(sbus.decision_funct_en), 64'd1);
    sbus.en = 1'b1;
    tick();
    sbus.en = 1'b0;
    done_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (sbus.done) done_cnt++;
    end
    check("ign_done_count", 64'(done_cnt), 64'd1);
    check("ign_dfo", 64'(sbus.decision_funct_out), 64'd55);

    // en held high: done every 9 cycles
    n = 0;
    sbus.en = 1'b1;
    for (int c = 0; c < 40 && n < 3; c++) begin
      tick();
      if (sbus.done) begin
        d_times[n] = c;
        n++;
      end
    end
    sbus.en = 1'b0;
    check("b2b_done_seen", 64'(n), 64'd3);
    if (n == 3) begin
      check("b2b_gap1", 64'(d_times[1] - d_times[0]), 64'd9);
      check("b2b_gap2", 64'(d_times[2] - d_times[1]), 64'd9);
    end
    repeat (12) tick();

    // Reset mid-ACCUM
    set_coefs(-1, -1, -1, -1);
    sbus.en = 1'b1;
    tick();
    sbus.en = 1'b0;
    repeat (5) tick();
    check("mid_in_accum", 64'(sbus.decision_funct_en), 64'd1);
    rst = 1'b1;
    tick();
    check("mid_rst_busy", 64'(sbus.kernel_busy), 64'd0);
    check("mid_rst_dfen", 64'(sbus.decision_funct_en), 64'd0);
    check("mid_rst_addr", 64'(sbus.coef_addr), 64'd0);
    check("mid_rst_dfo", 64'(sbus.decision_funct_out), 64'd0);
    check("mid_rst_y", 64'(sbus.y_class), 64'd0);
    check("mid_rst_done", 64'(sbus.done), 64'd0);
    rst = 1'b0;
    set_coefs(1, -1, 2, 0);
    tick();
    run_small("post_rst", 56'd55, 1'b1);

    // Default instance: 87*(-32768)*(2^40-1) - 32768 mod 2^56 = 2^55 + 0x2B0000
    dbus.en = 1'b1;
    tick();
    dbus.en = 1'b0;
    n = 0;
    while (!dbus.done && n < 1000) begin
      tick();
      n++;
    end
    check("def_latency", 64'(n), 64'd872);
    check("def_dfo", 64'(dbus.decision_funct_out), 64'h0080_0000_002B_0000);
    check("def_y", 64'(dbus.y_class), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/svm_decision_unit.md
Name: svm_decision_unit

Overview:
- Stage‑1 SVM classifier back end: sequences the kernel-compute phase, then serially accumulates Σ kernel[i]·coef[i] over all support vectors, adds the bias and outputs the decision value and class bit.
- Sits after the parallel per-SV dot-product kernels. Owns phase control (kernel stall, accumulate enable) and the decision-function datapath.

Parameters:
- XLEN_PIXEL, 8, pixel width; kernel value width KW = 5*XLEN_PIXEL, coefficient/bias width CW = 2*XLEN_PIXEL.
- NUM_OF_SV, 87, number of support vectors (≥1).
- DECISION_FUNCT_SIZE, 56, accumulator and output width (≥ KW+CW).
- KERNEL_LATENCY, 784, cycles the kernel phase lasts (≥1).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- en  in  1  start request; sampled only in IDLE.
- kernel_out  in  NUM_OF_SV*KW  packed unsigned kernel values; entry i at bits [i*KW +: KW]; must be stable during ACCUM.
- coef_addr  out  clog2(NUM_OF_SV) (min 1)  SV index being accumulated.
- coef_data  in  CW  signed two's-complement dual coefficient for coef_addr; combinational, same cycle.
- b  in  CW  signed two's-complement bias; sampled in FINISH.
- kernel_busy  out  1  high during KERNEL (stall to upstream memory/kernels).
- decision_funct_en  out  1  high during ACCUM.
- decision_funct_out  out  DECISION_FUNCT_SIZE  signed decision value, registered.
- y_class  out  1  1 when decision_funct_out ≥ 0, else 0.
- done  out  1  one-cycle pulse when results update.

Behaviour:
- Reset: state IDLE, index 0, accumulator 0, decision_funct_out 0, y_class 0, done 0, kernel_busy 0, decision_funct_en 0, coef_addr 0.
- FSM states: IDLE → KERNEL → ACCUM → FINISH → IDLE.
- IDLE: when en=1 at an edge, clear the accumulator and the cycle counter, then go to KERNEL.
- KERNEL: kernel_busy=1 for exactly KERNEL_LATENCY cycles, then go to ACCUM with index 0.
- ACCUM: decision_funct_en=1 and coef_addr=index.
  - Each edge: acc += sign_ext(coef_data) × zero_ext(kernel_out[index]).
  - Index increments by 1. After index NUM_OF_SV−1 has been added, go to FINISH. This is exactly NUM_OF_SV cycles.
- FINISH (1 cycle): at its edge, register decision_funct_out = acc + sign_ext(b) and y_class = ~MSB of that sum. done=1 for the following cycle; return to IDLE.
- Latency: with en sampled at edge E0, done is high after edge E0+KERNEL_LATENCY+NUM_OF_SV+1 for one cycle.
- Arithmetic: two's complement modulo 2^DECISION_FUNCT_SIZE; wrap on overflow, no saturation.
- decision_funct_out and y_class hold their values until the next FINISH or rst.
- en in non-IDLE states is ignored; no queuing.
- en held high continuously: a new run starts on the edge after done (back-to-back).
- rst at any state aborts the run immediately; outputs return to reset values.

Decomposition:
- Shared package svm_pkg:
  - width constants KW, CW, DECISION_FUNCT_SIZE defaults;
  - state enum {IDLE, KERNEL, ACCUM, FINISH};
  - index-width function.
- One sub-module, svm_phase_ctrl: FSM plus counters, driving kernel_busy, decision_funct_en, coef_addr, the acc-clear, finish strobe and done.
- The MAC/accumulator datapath stays in svm_decision_unit.

Test Plan:
- Test parameters: NUM_OF_SV=4, KERNEL_LATENCY=3.
- Nominal: kernels [10,20,30,40], coefs [1,−1,2,0], b=5, pulse en → decision_funct_out=55, y_class=1, done exactly 8 edges after en edge; kernel_busy high 3 cycles; decision_funct_en high 4 cycles with coef_addr 0,1,2,3.
- Negative: same kernels, coefs all −1, b=0 → decision_funct_out = −100 (2^56−100), y_class=0.
- Zero boundary: coefs all 0, b=0 → decision_funct_out=0, y_class=1.
- en pulsed during KERNEL and ACCUM → ignored; only one done; result unchanged. en held high → back-to-back runs with done every 9 cycles.
- rst asserted mid-ACCUM → next cycle all outputs 0 and state IDLE; a subsequent en gives the correct nominal result 55.
- Default params:
  - kernel entries = 2^40−1, coefs = −32768, b = −32768;
  - check the wrapped 56-bit result matches a golden model.
